// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius colour-sequence game blocks.
// Optional feature macro used by the player: GENIUS_SEQ_PLAYER_ABORT_EN.
package genius_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int GENIUS_NIB   = 4;
  localparam int GENIUS_STEPS = 16;

  localparam logic [3:0] LED_0 = 4'b0001;
  localparam logic [3:0] LED_1 = 4'b0010;
  localparam logic [3:0] LED_2 = 4'b0100;
  localparam logic [3:0] LED_3 = 4'b1000;

endpackage

// File: rtl/genius_tick_timer.sv
// Counts level-rate tick strobes up to a loadable limit; expire marks the
// tick that reaches the limit, after which the count restarts from zero.
module genius_tick_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic          expire
);

  logic [CW-1:0] cnt;

  assign expire = tick && !clr && (cnt == limit - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/genius_seq_player.sv
// Plays the latched colour sequence steps 0..ROUND on the LEDs, paced by TICK.
// Define GENIUS_SEQ_PLAYER_ABORT_EN to add the ABORT input.
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int P_NIB       = GENIUS_NIB,
  parameter int P_STEPS     = GENIUS_STEPS,
  parameter int P_ON_TICKS  = 2,
  parameter int P_GAP_TICKS = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     R_N,
`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
  input  logic                     ABORT,
`endif
  input  logic                     START,
  input  logic [3:0]               ROUND,
  input  logic [P_NIB*P_STEPS-1:0] SEQ,
  input  logic                     TICK,
  output logic [P_NIB-1:0]         leds,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [3:0]               STEP
);

  localparam int SW   = P_NIB * P_STEPS;
  localparam int TMAX = (P_ON_TICKS > P_GAP_TICKS) ? P_ON_TICKS : P_GAP_TICKS;
  localparam int CW   = $clog2(TMAX + 1);

  state_t         state;
  logic [SW-1:0]  seq_lat;
  logic [3:0]     round_lat;
  logic [CW-1:0]  limit;
  logic           expire;
  logic           tmr_clr;
  logic           abort_w;

`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [P_NIB-1:0] nib_at(input logic [SW-1:0] seq,
                                              input logic [3:0]    idx);
    return seq[idx*P_NIB +: P_NIB];
  endfunction

  // Timer is held clear while idle so a TICK on the accepted START edge is not counted.
  assign limit   = (state == GAP) ? CW'(P_GAP_TICKS) : CW'(P_ON_TICKS);
  assign tmr_clr = (state == IDLE) || abort_w;

  genius_tick_timer #(
    .CW (CW)
  ) u_timer (
    .clk    (CLOCK_50),
    .rst_n  (R_N),
    .clr    (tmr_clr),
    .tick   (TICK),
    .limit  (limit),
    .expire (expire)
  );

  always_ff @(posedge CLOCK_50 or negedge R_N) begin
    if (!R_N) begin
      state     <= IDLE;
      seq_lat   <= '0;
      round_lat <= '0;
      leds      <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      STEP      <= '0;
    end else begin
      DONE <= 1'b0;
      if (abort_w && state != IDLE) begin
        state <= IDLE;
        leds  <= '0;
        BUSY  <= 1'b0;
        STEP  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              seq_lat   <= SEQ;
              round_lat <= ROUND;
              STEP      <= '0;
              leds      <= SEQ[P_NIB-1:0];
              BUSY      <= 1'b1;
              state     <= SHOW;
            end
          end
          SHOW: begin
            if (expire) begin
              leds  <= '0;
              state <= GAP;
            end
          end
          GAP: begin
            if (expire) begin
              if (STEP == round_lat) begin
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
                state <= IDLE;
              end else begin
                STEP  <= STEP + 4'd1;
                leds  <= nib_at(seq_lat, STEP + 4'd1);
                state <= SHOW;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_genius_seq_player.sv
// Randomised self-checking bench for genius_seq_player with a tick-count reference model.
module tb_genius_seq_player;

  localparam int ON  = 2;
  localparam int GP  = 1;
  localparam int PER = ON + GP;

  logic        CLOCK_50 = 1'b0;
  logic        R_N;
  logic        START;
  logic [3:0]  ROUND;
  logic [63:0] SEQ;
  logic        TICK;
`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
  logic        ABORT;
`endif
  wire  [3:0]  leds;
  wire         BUSY;
  wire         DONE;
  wire  [3:0]  STEP;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  genius_seq_player #(
    .P_NIB       (4),
    .P_STEPS     (16),
    .P_ON_TICKS  (ON),
    .P_GAP_TICKS (GP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .R_N      (R_N),
`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
    .ABORT    (ABORT),
`endif
    .START    (START),
    .ROUND    (ROUND),
    .SEQ      (SEQ),
    .TICK     (TICK),
    .leds     (leds),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .STEP     (STEP)
  );

  // Reference: after k counted ticks, step = k/PER, lit while k%PER < ON,
  // and the play ends after (r+1)*PER ticks with a DONE pulse.
  task automatic run_play(input string name, input logic [63:0] s, input logic [3:0] r,
                          input int gap, input bit tick_at_start, input bit noise,
                          input bit back2back);
    int k, total, cyc, budget, st;
    bit inj;
    logic [3:0] e_leds, e_step;
    logic e_busy, e_done;
    total  = (int'(r) + 1) * PER;
    budget = total * gap + 20;
    SEQ = s; ROUND = r; START = 1'b1; TICK = tick_at_start;
    @(posedge CLOCK_50); #1;
    START = 1'b0; TICK = 1'b0;
    k = 0; cyc = 0; inj = 1'b0;
    while (1) begin
      if (k < total) begin
        st     = k / PER;
        e_step = 4'(st);
        e_leds = ((k % PER) < ON) ? s[st*4 +: 4] : 4'h0;
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_step = r;
        e_leds = 4'h0;
        e_busy = 1'b0;
        e_done = 1'b1;
      end
      n_tests++;
      if ({leds, BUSY, DONE, STEP} !== {e_leds, e_busy, e_done, e_step}) begin
        n_fail++;
        $display("FAIL %s tick=%0d: leds=%h busy=%b done=%b step=%0d, want leds=%h busy=%b done=%b step=%0d",
                 name, k, leds, BUSY, DONE, STEP, e_leds, e_busy, e_done, e_step);
      end
      if (k == total) break;
      if (cyc >= budget) begin
        n_tests++; n_fail++;
        $display("FAIL %s timeout: ticks=%0d, want %0d", name, k, total);
        break;
      end
      TICK = ((cyc % gap) == gap - 1);
      if (noise && !inj && k == 7 * PER) begin
        START = 1'b1;
        SEQ   = {$urandom, $urandom};
        ROUND = 4'($urandom);
        inj   = 1'b1;
      end
      @(posedge CLOCK_50); #1;
      if (TICK) k++;
      TICK = 1'b0; START = 1'b0;
      cyc++;
    end
    if (!back2back) begin
      @(posedge CLOCK_50); #1;
      n_tests++;
      if ({leds, BUSY, DONE, STEP} !== {4'h0, 1'b0, 1'b0, r}) begin
        n_fail++;
        $display("FAIL %s after_done: leds=%h busy=%b done=%b step=%0d, want 0/0/0/%0d",
                 name, leds, BUSY, DONE, STEP, r);
      end
    end
  endtask

  task automatic test_reset();
    R_N = 1'b0; START = 1'b0; TICK = 1'b0; ROUND = '0; SEQ = '0;
`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
    ABORT = 1'b0;
`endif
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_tests++;
    if ({leds, BUSY, DONE, STEP} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_state: leds=%h busy=%b done=%b step=%0d, want all 0", leds, BUSY, DONE, STEP);
    end
    R_N = 1'b1;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset_mid();
    int k, cyc;
    bit seen;
    SEQ = {$urandom, $urandom}; ROUND = 4'd3; START = 1'b1;
    @(posedge CLOCK_50); #1;
    START = 1'b0;
    k = 0; cyc = 0;
    while (k < PER + 1 && cyc < 100) begin
      TICK = (cyc % 2 == 1);
      @(posedge CLOCK_50); #1;
      if (TICK) k++;
      TICK = 1'b0;
      cyc++;
    end
    #2 R_N = 1'b0;
    #1;
    n_tests++;
    if ({leds, BUSY, DONE, STEP} !== 10'h0 || k != PER + 1) begin
      n_fail++;
      $display("FAIL reset_mid: leds=%h busy=%b done=%b step=%0d ticks=%0d, want all 0 after %0d ticks",
               leds, BUSY, DONE, STEP, k, PER + 1);
    end
    repeat (2) @(posedge CLOCK_50);
    #1 R_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      TICK = (i % 2 == 0);
      @(posedge CLOCK_50); #1;
      TICK = 1'b0;
      if (DONE || BUSY) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: done/busy seen=%b, want 0", seen);
    end
  endtask

  task automatic test_basic();
    run_play("basic", 64'h8421, 4'd3, 10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    run_play("single", {$urandom, $urandom_range(15, 0) << 4 | 32'h4}, 4'd0, 10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_length();
    run_play("full", {$urandom, $urandom}, 4'd15, $urandom_range(3, 1), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_play("coincide", {$urandom, $urandom}, 4'($urandom_range(4, 1)), 2, 1'b1, 1'b0, 1'b1);
    run_play("b2b", {$urandom, $urandom}, 4'($urandom_range(4, 0)), 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_play("random", {$urandom, $urandom}, 4'($urandom), $urandom_range(4, 1),
               1'($urandom), 1'b0, 1'b0);
  endtask

`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
  task automatic test_abort();
    int k;
    bit seen;
    SEQ = {$urandom, $urandom}; ROUND = 4'd3; START = 1'b1;
    @(posedge CLOCK_50); #1;
    START = 1'b0;
    for (k = 0; k < 2 * PER; k++) begin
      TICK = 1'b1;
      @(posedge CLOCK_50); #1;
      TICK = 1'b0;
    end
    TICK = 1'b1; ABORT = 1'b1;
    @(posedge CLOCK_50); #1;
    TICK = 1'b0; ABORT = 1'b0;
    n_tests++;
    if ({leds, BUSY, DONE, STEP} !== 10'h0) begin
      n_fail++;
      $display("FAIL abort: leds=%h busy=%b done=%b step=%0d, want all 0", leds, BUSY, DONE, STEP);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      TICK = 1'b1;
      @(posedge CLOCK_50); #1;
      TICK = 1'b0;
      if (DONE || BUSY) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_done: done/busy seen=%b, want 0", seen);
    end
    run_play("after_abort", {$urandom, $urandom}, 4'd2, 2, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_single();
    test_full_length();
    test_back_to_back();
    test_random();
`ifdef GENIUS_SEQ_PLAYER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
